// File: rtl/jelly_texture_blk_arbiter_pkg.sv
// Shared helpers for the texture block-fetch arbiter: the width ladder used
// to size id and counter fields, and the widest requester id type.
package jelly_texture_blk_arbiter_pkg;

  // Widest supported requester population (ids 0..15).
  typedef logic [3:0] req_id_t;

  // Bits needed to hold the values 0..n-1.
  function automatic int width_ladder(input int n);
    if (n <= 2)  return 1;
    if (n <= 4)  return 2;
    if (n <= 8)  return 3;
    if (n <= 16) return 4;
    return 5;
  endfunction

endpackage

// File: rtl/jelly_texture_blk_arbiter_rr.sv
// Combinational round-robin picker: first eligible requester at or after rr,
// wrapping from NUM-1 back to 0.
module jelly_texture_blk_arbiter_rr
  import jelly_texture_blk_arbiter_pkg::*;
#(
  parameter int NUM      = 4,
  parameter int ID_WIDTH = 2
)
(
  input  logic [NUM-1:0]      eligible,
  input  logic [ID_WIDTH-1:0] rr,
  output logic [NUM-1:0]      grant,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any_grant
);

  int idx;

  // Scan NUM positions starting at rr; the first eligible one wins.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM) begin
        idx = idx - NUM;
      end
      if (!any_grant && eligible[idx]) begin
        any_grant   = 1'b1;
        grant[idx]  = 1'b1;
        winner      = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/jelly_texture_blk_arbiter.sv
// Round-robin arbiter sharing one texture block-fetch path among NUM cache
// units, with a per-requester cap on in-flight blocks and a registered
// output slice tagged with the requester id.
module jelly_texture_blk_arbiter
  import jelly_texture_blk_arbiter_pkg::*;
#(
  parameter int NUM             = 4,
  parameter int ID_WIDTH        = 2,
  parameter int USER_WIDTH      = 1,
  parameter int ADDR_X_WIDTH    = 12,
  parameter int ADDR_Y_WIDTH    = 12,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 3
)
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM*USER_WIDTH-1:0]   s_user,
  input  logic [NUM*ADDR_X_WIDTH-1:0] s_addrx,
  input  logic [NUM*ADDR_Y_WIDTH-1:0] s_addry,
  input  logic [NUM-1:0]              s_valid,
  output logic [NUM-1:0]              s_ready,
  output logic [ID_WIDTH-1:0]         m_id,
  output logic [USER_WIDTH-1:0]       m_user,
  output logic [ADDR_X_WIDTH-1:0]     m_addrx,
  output logic [ADDR_Y_WIDTH-1:0]     m_addry,
  output logic                        m_valid,
  input  logic                        m_ready,
  input  logic [ID_WIDTH-1:0]         r_id,
  input  logic                        r_last,
  input  logic                        r_valid
);

  localparam int ID_MIN_WIDTH  = width_ladder(NUM);
  localparam int CNT_MIN_WIDTH = width_ladder(MAX_OUTSTANDING + 1);

  if (ID_WIDTH < ID_MIN_WIDTH) begin : g_id_width_check
    $error("ID_WIDTH too narrow for NUM requesters");
  end
  if (CNT_WIDTH < CNT_MIN_WIDTH) begin : g_cnt_width_check
    $error("CNT_WIDTH too narrow for MAX_OUTSTANDING");
  end

  logic [CNT_WIDTH-1:0] cnt [NUM];
  logic [ID_WIDTH-1:0]  rr;
  logic [NUM-1:0]       eligible;
  logic [NUM-1:0]       grant;
  logic [NUM-1:0]       inc;
  logic [NUM-1:0]       dec;
  logic [ID_WIDTH-1:0]  winner;
  logic                 any_grant;
  logic                 load;
  logic                 grant_en;

  // A requester competes only while it has a free in-flight slot.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM; i++) begin
      eligible[i] = s_valid[i] && (cnt[i] < CNT_WIDTH'(MAX_OUTSTANDING));
    end
  end

  jelly_texture_blk_arbiter_rr #(
    .NUM      (NUM),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .eligible  (eligible),
    .rr        (rr),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  // Grant only when the output slice can take a new entry; never during reset.
  always_comb begin
    load     = !m_valid || m_ready;
    grant_en = load && any_grant && !reset;
    s_ready  = grant_en ? grant : '0;
    inc      = s_ready;
    dec      = '0;
    for (int i = 0; i < NUM; i++) begin
      dec[i] = r_valid && r_last && (int'(r_id) == i);
    end
  end

  // Pointer moves just past the actual winner, skipping full requesters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr <= '0;
    end else if (grant_en) begin
      rr <= (winner == ID_WIDTH'(NUM - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Output register slice; data fields hold when the entry drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_id    <= '0;
      m_user  <= '0;
      m_addrx <= '0;
      m_addry <= '0;
    end else if (grant_en) begin
      m_valid <= 1'b1;
      m_id    <= winner;
      m_user  <= s_user[int'(winner)*USER_WIDTH +: USER_WIDTH];
      m_addrx <= s_addrx[int'(winner)*ADDR_X_WIDTH +: ADDR_X_WIDTH];
      m_addry <= s_addry[int'(winner)*ADDR_Y_WIDTH +: ADDR_Y_WIDTH];
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // In-flight counters: a grant and a completion in one cycle cancel, and a
  // completion at zero (stale or bogus) is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (inc[i] && !(dec[i] && cnt[i] != '0)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec[i] && !inc[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jelly_texture_blk_arbiter.sv
// Directed bench for jelly_texture_blk_arbiter (NUM=4, MAX_OUTSTANDING=4).
module tb_jelly_texture_blk_arbiter;
  import jelly_texture_blk_arbiter_pkg::*;

  localparam int NUM = 4;
  localparam int IDW = 2;
  localparam int UW  = 1;
  localparam int XW  = 12;
  localparam int YW  = 12;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM*UW-1:0]    s_user;
  logic [NUM*XW-1:0]    s_addrx;
  logic [NUM*YW-1:0]    s_addry;
  logic [NUM-1:0]       s_valid;
  logic [NUM-1:0]       s_ready;
  logic [IDW-1:0]       m_id;
  logic [UW-1:0]        m_user;
  logic [XW-1:0]        m_addrx;
  logic [YW-1:0]        m_addry;
  logic                 m_valid;
  logic                 m_ready;
  logic [IDW-1:0]       r_id;
  logic                 r_last;
  logic                 r_valid;

  int checks   = 0;
  int failures = 0;

  jelly_texture_blk_arbiter #(
    .NUM(NUM), .ID_WIDTH(IDW), .USER_WIDTH(UW), .ADDR_X_WIDTH(XW),
    .ADDR_Y_WIDTH(YW), .MAX_OUTSTANDING(4), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .s_user(s_user), .s_addrx(s_addrx),
    .s_addry(s_addry), .s_valid(s_valid), .s_ready(s_ready), .m_id(m_id),
    .m_user(m_user), .m_addrx(m_addrx), .m_addry(m_addry), .m_valid(m_valid),
    .m_ready(m_ready), .r_id(r_id), .r_last(r_last), .r_valid(r_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [UW-1:0] u, input logic [XW-1:0] x,
                         input logic [YW-1:0] y);
    s_user[i*UW +: UW]   = u;
    s_addrx[i*XW +: XW]  = x;
    s_addry[i*YW +: YW]  = y;
  endtask

  task automatic completion(input logic [IDW-1:0] id, input logic last);
    r_valid = 1'b1;
    r_last  = last;
    r_id    = id;
  endtask

  task automatic no_completion();
    r_valid = 1'b0;
    r_last  = 1'b0;
    r_id    = '0;
  endtask

  initial begin
    reset   = 1'b1;
    s_user  = '0;
    s_addrx = '0;
    s_addry = '0;
    s_valid = '1;
    m_ready = 1'b1;
    no_completion();
    step();
    step();
    check("reset_s_ready", 64'(s_ready), 64'h0);
    check("reset_m_valid", 64'(m_valid), 64'h0);
    check("reset_m_id",    64'(m_id),    64'h0);
    check("reset_m_addrx", 64'(m_addrx), 64'h0);
    check("reset_cnt2",    64'(dut.cnt[2]), 64'h0);

    // single requester 2
    reset   = 1'b0;
    s_valid = 4'b0100;
    set_req(2, 1'b1, 12'h040, 12'h010);
    #1;
    check("single_s_ready", 64'(s_ready), 64'h4);
    step();
    s_valid = '0;
    #1;
    check("single_m_valid", 64'(m_valid), 64'h1);
    check("single_m_id",    64'(m_id),    64'h2);
    check("single_m_addrx", 64'(m_addrx), 64'h040);
    check("single_m_addry", 64'(m_addry), 64'h010);
    check("single_m_user",  64'(m_user),  64'h1);
    check("single_s_ready_off", 64'(s_ready), 64'h0);
    check("single_cnt2",    64'(dut.cnt[2]), 64'h1);
    completion(2'd2, 1'b1);
    step();
    no_completion();
    check("single_drain_m_valid", 64'(m_valid), 64'h0);
    check("single_done_cnt2", 64'(dut.cnt[2]), 64'h0);

    // round-robin from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      set_req(i, UW'(i), XW'(12'h100 + i), YW'(12'h200 + i));
    end
    s_valid = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      #1;
      check("rr_s_ready", 64'(s_ready), 64'(1 << (k % 4)));
      step();
      check("rr_m_id",    64'(m_id),    64'(k % 4));
      check("rr_m_addrx", 64'(m_addrx), 64'(12'h100 + (k % 4)));
    end
    #1;
    check("rr_full_s_ready", 64'(s_ready), 64'h0);
    step();
    check("rr_full_m_valid", 64'(m_valid), 64'h0);
    check("rr_full_s_ready2", 64'(s_ready), 64'h0);
    for (int i = 0; i < NUM; i++) begin
      check("rr_full_cnt", 64'(dut.cnt[i]), 64'h4);
    end

    // credit release: slot usable only the cycle after the completion
    s_valid = 4'b0001;
    completion(2'd0, 1'b1);
    #1;
    check("credit_no_bypass", 64'(s_ready), 64'h0);
    step();
    no_completion();
    #1;
    check("credit_freed", 64'(s_ready), 64'h1);
    step();
    check("credit_m_id",  64'(m_id), 64'h0);
    check("credit_cnt0",  64'(dut.cnt[0]), 64'h4);
    check("credit_stall", 64'(s_ready), 64'h0);

    // beat without last does nothing
    s_valid = '0;
    completion(2'd1, 1'b0);
    step();
    no_completion();
    check("nolast_cnt1", 64'(dut.cnt[1]), 64'h4);

    // grant and completion together for requester 1
    completion(2'd1, 1'b1);
    step();
    check("free1_cnt1", 64'(dut.cnt[1]), 64'h3);
    s_valid = 4'b0010;
    #1;
    check("simul_s_ready", 64'(s_ready), 64'h2);
    step();
    no_completion();
    s_valid = '0;
    check("simul_cnt1",    64'(dut.cnt[1]), 64'h3);
    check("simul_m_id",    64'(m_id),    64'h1);
    check("simul_m_valid", 64'(m_valid), 64'h1);

    // reset mid-stream with the output occupied
    m_ready = 1'b0;
    s_valid = 4'b1111;
    reset   = 1'b1;
    #1;
    check("midrst_s_ready", 64'(s_ready), 64'h0);
    step();
    check("midrst_m_valid", 64'(m_valid), 64'h0);
    check("midrst_m_id",    64'(m_id),    64'h0);
    for (int i = 0; i < NUM; i++) begin
      check("midrst_cnt", 64'(dut.cnt[i]), 64'h0);
    end
    reset   = 1'b0;
    m_ready = 1'b1;
    #1;
    check("midrst_first_s_ready", 64'(s_ready), 64'h1);
    step();
    check("midrst_first_m_id",    64'(m_id),    64'h0);
    check("midrst_first_m_addrx", 64'(m_addrx), 64'h100);

    // stale completion at zero count is dropped
    s_valid = '0;
    completion(2'd3, 1'b1);
    step();
    no_completion();
    check("underflow_cnt3", 64'(dut.cnt[3]), 64'h0);
    check("underflow_m_valid", 64'(m_valid), 64'h0);

    // back-pressure
    s_valid = 4'b1111;
    #1;
    check("bp_first_s_ready", 64'(s_ready), 64'h2);
    step();
    check("bp_first_m_id", 64'(m_id), 64'h1);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_s_ready", 64'(s_ready), 64'h0);
      step();
      check("bp_m_valid", 64'(m_valid), 64'h1);
      check("bp_m_id",    64'(m_id),    64'h1);
      check("bp_m_addrx", 64'(m_addrx), 64'h101);
    end
    check("bp_cnt1", 64'(dut.cnt[1]), 64'h1);
    check("bp_cnt2", 64'(dut.cnt[2]), 64'h0);
    m_ready = 1'b1;
    #1;
    check("bp_release_s_ready", 64'(s_ready), 64'h4);
    step();
    check("bp_release_m_id",    64'(m_id),    64'h2);
    check("bp_release_m_addry", 64'(m_addry), 64'h202);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
